// File: rtl/host_bus_master_if.sv
// Command, write-data, response and host-bus signals of host_bus_master.
// The master modport is the initiator's view; slave is the environment side.
interface host_bus_master_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 4
);
    // command port
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_wr_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [LEN_W-1:0]  cmd_len_i;
    // write data stream
    logic              wdata_valid_i;
    logic              wdata_ready_o;
    logic [DATA_W-1:0] wdata_i;
    // read response stream
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_last_o;
    // host select/write bus
    logic              host_sel_o;
    logic              host_wr_o;
    logic [ADDR_W-1:0] host_addr_o;
    logic [DATA_W-1:0] host_wdata_o;
    logic [DATA_W-1:0] host_rdata_i;

    modport master (
        input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i,
        input  wdata_valid_i, wdata_i, rsp_ready_i, host_rdata_i,
        output cmd_ready_o, wdata_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o,
        output host_sel_o, host_wr_o, host_addr_o, host_wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i,
        output wdata_valid_i, wdata_i, rsp_ready_i, host_rdata_i,
        input  cmd_ready_o, wdata_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o,
        input  host_sel_o, host_wr_o, host_addr_o, host_wdata_o
    );
endinterface

// File: rtl/host_bus_master.sv
// Burst initiator for the select/write host bus: takes burst commands, issues
// one host access per cycle with wrapping addresses, and buffers read data in
// a small response FIFO with valid/ready backpressure.
module host_bus_master #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                host_clk_i,
    input  logic                reset_n_i,
    host_bus_master_if.master   bus,
    output logic                done_o,
    output logic                busy_o
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              done_q, done_d;

    logic [ENT_W-1:0]  fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cmd_ready_c;
    logic              wdata_ready_c;
    logic              sel_c;
    logic              wr_c;
    logic [ADDR_W-1:0] haddr_c;
    logic [DATA_W-1:0] hwdata_c;
    logic              push_c;
    logic              push_last_c;
    logic              pop_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [ENT_W-1:0]  head_c;

    // FIFO occupancy flags; a pop in the same cycle never frees space for a push
    always_comb begin
        fifo_full_c  = (cnt_q == CNT_W'(RSP_DEPTH));
        fifo_empty_c = (cnt_q == '0);
        pop_c        = !fifo_empty_c && bus.rsp_ready_i;
        head_c       = fifo_q[rd_ptr_q];
    end

    // Next-state and host-bus decode; host outputs are combinational for zero latency
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remain_d      = remain_q;
        done_d        = 1'b0;
        cmd_ready_c   = 1'b0;
        wdata_ready_c = 1'b0;
        sel_c         = 1'b0;
        wr_c          = 1'b0;
        haddr_c       = '0;
        hwdata_c      = '0;
        push_c        = 1'b0;
        push_last_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid_i) begin
                    addr_d   = bus.cmd_addr_i;
                    remain_d = bus.cmd_len_i;
                    state_d  = bus.cmd_wr_i ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wdata_ready_c = 1'b1;
                wr_c          = 1'b1;
                haddr_c       = addr_q;
                if (bus.wdata_valid_i) begin
                    sel_c    = 1'b1;
                    hwdata_c = bus.wdata_i;
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                haddr_c = addr_q;
                if (!fifo_full_c) begin
                    sel_c       = 1'b1;
                    push_c      = 1'b1;
                    push_last_c = (remain_q == '0);
                    addr_d      = addr_q + ADDR_W'(1);
                    remain_d    = remain_q - LEN_W'(1);
                    if (remain_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer and count update; simultaneous push and pop keeps the count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FSM, address, beat counter and done pulse registers
    always_ff @(posedge host_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            done_q   <= done_d;
        end
    end

    // Response FIFO storage and pointers; reset discards buffered read data
    always_ff @(posedge host_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_c) begin
                fifo_q[wr_ptr_q] <= {push_last_c, bus.host_rdata_i};
            end
        end
    end

    assign bus.cmd_ready_o   = cmd_ready_c;
    assign bus.wdata_ready_o = wdata_ready_c;
    assign bus.host_sel_o    = sel_c;
    assign bus.host_wr_o     = wr_c;
    assign bus.host_addr_o   = haddr_c;
    assign bus.host_wdata_o  = hwdata_c;
    assign bus.rsp_valid_o   = !fifo_empty_c;
    assign bus.rsp_data_o    = fifo_empty_c ? '0 : head_c[DATA_W-1:0];
    assign bus.rsp_last_o    = !fifo_empty_c && head_c[DATA_W];
    assign done_o            = done_q;
    assign busy_o            = (state_q != ST_IDLE);

endmodule

// File: doc/host_bus_master.md
Name:
host_bus_master

Overview:
- Initiator for the 4-bit-address / 8-bit-data host select/write bus that the memory-style host slaves respond to.
- Accepts burst commands on a valid/ready port and streams write data in.
- Issues one host access per cycle with incrementing, wrapping addresses.
- Returns read data through a small response FIFO with valid/ready backpressure. It sits between the test or CPU side and any host-bus slave.

Parameters:
- ADDR_W, 4, host address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, host data width.
- LEN_W, 4, burst length field width; beats = cmd_len_i + 1.
- RSP_DEPTH, 4, read response FIFO depth in entries; power of 2, at least 2.

Ports:
- host_clk_i  in  1  clock; all logic on rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_wr_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  ADDR_W  start address.
- cmd_len_i  in  LEN_W  beats minus one.
- wdata_valid_i  in  1  write beat available.
- wdata_ready_o  out  1  write beat consumed.
- wdata_i  in  DATA_W  write beat data.
- rsp_valid_o  out  1  read beat available.
- rsp_ready_i  in  1  read beat consumed.
- rsp_data_o  out  DATA_W  read beat data.
- rsp_last_o  out  1  final beat of a read burst.
- done_o  out  1  one-cycle pulse, burst fully issued on host bus.
- busy_o  out  1  state is not IDLE.
- host_sel_o  out  1  host access strobe.
- host_wr_o  out  1  host write select.
- host_addr_o  out  ADDR_W  host address.
- host_wdata_o  out  DATA_W  host write data.
- host_rdata_i  in  DATA_W  host read data; slave drives it combinationally in the same cycle as sel&&!wr.

Behaviour:
- Reset (asynchronous, immediate on reset_n_i low): state IDLE, address and beat counters 0, FIFO empty.
  - Outputs during reset: host_sel_o=0, host_wr_o=0, host_addr_o=0, host_wdata_o=0, rsp_valid_o=0, rsp_last_o=0, rsp_data_o=0, done_o=0, busy_o=0, wdata_ready_o=0, cmd_ready_o=1.
- FSM states: IDLE, WRITE, READ.
  - IDLE: cmd_ready_o=1. On cmd_valid_i, latch addr into addr_q and len into remaining count, then go to WRITE if cmd_wr_i else READ.
  - WRITE/READ: cmd_ready_o=0.
- Host outputs are combinational from state and registers, giving zero added latency:
  - host_addr_o = addr_q in WRITE/READ, 0 in IDLE.
  - host_wr_o = (state==WRITE).
- WRITE:
  - wdata_ready_o=1.
  - host_sel_o = wdata_valid_i.
  - host_wdata_o = wdata_i when host_sel_o, else 0.
  - A beat is complete at the edge where wdata_valid_i=1. On that edge: addr_q increments mod 2^ADDR_W and the remaining count decrements.
  - No host access occurs in gap cycles.
- READ:
  - host_sel_o = (fifo_count < RSP_DEPTH). A pop in the same cycle does not free space.
  - On each edge with host_sel_o=1: push {last, host_rdata_i} into the FIFO, where last = (remaining==0). Then advance addr_q and remaining.
  - While the FIFO is full, host_sel_o=0 and the address holds.
- Burst end: on the edge completing the beat with remaining==0, go to IDLE. done_o is high for exactly the following cycle.
  - A new command may be accepted in that same cycle, so back-to-back bursts have one idle host cycle between them.
- Response FIFO:
  - rsp_valid_o = not empty; rsp_data_o and rsp_last_o come from the head entry, 0 when empty.
  - Pop on rsp_valid_o && rsp_ready_i.
  - Push and pop may happen in the same cycle; the count is unchanged.
  - The FIFO drains independently of the FSM, including after return to IDLE and during a following write burst.
- Address wrap: a burst may cross 2^ADDR_W-1 to 0. There is no error for len+1 > 2^ADDR_W; addresses simply repeat.
- busy_o = (state != IDLE).
- Reset mid-burst: the burst is abandoned and buffered read data is discarded; no done_o is generated.

Test Plan:
1. Single write: cmd wr=1 addr=3 len=0, wdata 0xA5 already valid -> one cycle with sel=1, wr=1, addr=3, wdata=0xA5; slave location 3 = 0xA5; done_o pulses the next cycle; cmd_ready_o returns to 1.
2. Wrapping read: slave preloaded with mem[i]=0x10+i; cmd wr=0 addr=14 len=3, rsp_ready_i=1 -> host addr 14,15,0,1 on consecutive sel cycles; rsp data 0x1E,0x1F,0x10,0x11; rsp_last_o only on 0x11.
3. Backpressure: rsp_ready_i=0, read addr=0 len=7, RSP_DEPTH=4 -> exactly 4 sel cycles, then sel=0 with addr held at 4. Raise rsp_ready_i -> all 8 beats 0x10..0x17 arrive in order with no loss or duplication; done_o once.
4. Write gaps: write addr=5 len=2, wdata_valid_i pattern 1,0,0,1,0,1 with data 0x01,0x02,0x03 -> sel only on valid cycles; addrs 5,6,7; slave holds 0x01,0x02,0x03.
5. Reset mid-read: reset_n_i low while beat 2 of an 8-beat read is issuing -> sel, rsp_valid_o and busy_o drop to 0 immediately; after release cmd_ready_o=1; a fresh 1-beat read returns correct data.
6. Full-sweep write then read: write addr=0 len=15 data 0xF0-i, then read addr=0 len=15 -> 16 responses match; last flag only on beat 16; one done_o per burst.
